// File: rtl/oka_seq_gf2_mult.sv
// Sequential overlap-free Karatsuba carry-less multiplier: one H-bit clmul core reused
// for z0, z2, z1 over three cycles, then recombined and optionally reduced mod x^W+POLY.
module oka_seq_gf2_mult #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = 16'h100B
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_reduce,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-2:0] out_y,
  output logic               out_reduced,
  output logic               busy
);

  // state | meaning
  // IDLE  | waiting for operands
  // Z0    | core computes al*bl
  // Z2    | core computes ah*bh
  // Z1    | core computes (al^ah)*(bl^bh); recombine on exit
  // RED   | fold product modulo x^WIDTH + POLY
  // OUT   | result presented until out_ready

  localparam int H = WIDTH / 2;
  localparam int Z = WIDTH - 1;
  localparam int Y = 2 * WIDTH - 1;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("oka_seq_gf2_mult: WIDTH must be even and >= 4");
  end

  typedef enum logic [2:0] {S_IDLE, S_Z0, S_Z2, S_Z1, S_RED, S_OUT} state_t;

  state_t         state, state_nxt;
  logic [H-1:0]   al, ah, bl, bh;
  logic           red_q;
  logic [Z-1:0]   z0, z2, core_y;
  logic [H-1:0]   op_a, op_b;
  logic           accept;
  logic [Y-1:0]   recomb, reduced;

  function automatic logic [Z-1:0] clmul(input logic [H-1:0] a, input logic [H-1:0] b);
    logic [Z-1:0] r;
    r = '0;
    for (int i = 0; i < H; i++) begin
      if (b[i]) r = r ^ ({{(Z-H){1'b0}}, a} << i);
    end
    return r;
  endfunction

  function automatic logic [Y-1:0] poly_mod(input logic [Y-1:0] v);
    logic [Y-1:0] r;
    r = v;
    for (int i = Y - 1; i >= WIDTH; i--) begin
      if (r[i]) r = r ^ ({{(Y-WIDTH-1){1'b0}}, 1'b1, POLY} << (i - WIDTH));
    end
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    in_ready  = rst_n & ((state == S_IDLE) | ((state == S_OUT) & out_ready));
    out_valid = (state == S_OUT);
    busy      = (state != S_IDLE);
    accept    = in_valid & in_ready;
    op_a      = al;
    op_b      = bl;
    case (state)
      S_IDLE: if (accept) state_nxt = S_Z0;
      S_Z0:   state_nxt = S_Z2;
      S_Z2: begin
        op_a      = ah;
        op_b      = bh;
        state_nxt = S_Z1;
      end
      S_Z1: begin
        op_a      = al ^ ah;
        op_b      = bl ^ bh;
        state_nxt = red_q ? S_RED : S_OUT;
      end
      S_RED:  state_nxt = S_OUT;
      S_OUT: begin
        if (out_ready) state_nxt = in_valid ? S_Z0 : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign core_y = clmul(op_a, op_b);

  // During Z1 the core output is z1; the middle term z0^z1^z2 lands at offset H.
  assign recomb = {{(Y-Z){1'b0}}, z0}
                ^ ({{(Y-Z){1'b0}}, z0 ^ z2 ^ core_y} << H)
                ^ ({{(Y-Z){1'b0}}, z2} << WIDTH);
  assign reduced = poly_mod(out_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      al          <= '0;
      ah          <= '0;
      bl          <= '0;
      bh          <= '0;
      red_q       <= 1'b0;
      z0          <= '0;
      z2          <= '0;
      out_y       <= '0;
      out_reduced <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        al    <= in_a[H-1:0];
        ah    <= in_a[WIDTH-1:H];
        bl    <= in_b[H-1:0];
        bh    <= in_b[WIDTH-1:H];
        red_q <= in_reduce;
      end
      case (state)
        S_Z0: z0 <= core_y;
        S_Z2: z2 <= core_y;
        S_Z1: begin
          out_y       <= recomb;
          out_reduced <= red_q;
        end
        S_RED: out_y <= reduced;
        default: ;
      endcase
    end
  end

endmodule
